pipe_skid_register: RTL and testbench

Elastic N-bit pipeline register with a valid/ready handshake on both sides and a one-entry skid buffer. It sits between pipeline stages as the flow-controlled counterpart of the plain load-enabled register. It computes its own internal load enables from downstream backpressure, so an upstream stage can keep issuing for one cycle after the downstream stage stalls without losing data. Throughput is one beat per cycle; no combinational path runs from m_ready to s_ready.

---
 rtl/pipe_skid_register.sv | 94 +++++++++
 tb/tb_pipe_skid_register.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_register.sv
// Elastic N-bit pipeline register with valid/ready handshakes and a one-entry skid buffer.
// All handshake outputs decode the state register, so m_ready never reaches s_ready combinationally.
module pipe_skid_register #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic [1:0]   occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   main_q, main_d;
    logic [N-1:0]   skid_q, skid_d;
    logic           accept, consume;

    assign s_ready = (state_q != TWO);
    assign m_valid = (state_q != EMPTY);
    assign m_data  = main_q;
    assign accept  = s_valid & s_ready;
    assign consume = m_valid & m_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            EMPTY: occupancy = 2'd0;
            ONE:   occupancy = 2'd1;
            TWO:   occupancy = 2'd2;
            BAD:   occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush drops both held beats but leaves the data registers untouched.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = s_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_d = s_data;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        skid_d  = s_data;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                BAD: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Scenario-driven bench for pipe_skid_register: a queue of accepted beats is compared
// against every beat the DUT hands downstream.
`timescale 1ns/1ps
module tb_pipe_skid_register;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  occupancy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q[$];

    pipe_skid_register #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    // Inputs are driven 1ns after the edge; outputs are sampled 2ns later, then time moves to the next edge + 1ns.
    task automatic tick(output bit acc, output bit con, output logic [31:0] md,
                        output logic mv, output logic sr, output logic [1:0] occ);
        #2;
        acc = s_valid && s_ready && !flush;
        con = m_valid && m_ready && !flush;
        md  = m_data;
        mv  = m_valid;
        sr  = s_ready;
        occ = occupancy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pop_exp();
        if (q.size() == 0) return 'x;
        return q.pop_front();
    endfunction

    task automatic test_reset();
        bit acc, con; logic [31:0] md, exp; logic mv, sr; logic [1:0] occ;
        rst = 1'b0; flush = 1'b0; s_valid = 1'b1; m_ready = 1'b1; s_data = 32'h12345678;
        #3;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d, required 0", occupancy); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data: got %h, required 00000000", m_data); end
        @(posedge clk); #1;
        rst = 1'b1;
        s_valid = 1'b1; s_data = 32'hDEADBEEF; m_ready = 1'b0;
        tick(acc, con, md, mv, sr, occ);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL reset_first_accept: got %b, required 1", acc); end
        if (acc) q.push_back(32'hDEADBEEF);
        s_valid = 1'b0;
        tick(acc, con, md, mv, sr, occ);
        n_checks++; if (mv !== 1'b1) begin n_fail++; $display("FAIL reset_latency_valid: got %b, required 1", mv); end
        n_checks++; if (md !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_latency_data: got %h, required deadbeef", md); end
        m_ready = 1'b1;
        tick(acc, con, md, mv, sr, occ);
        n_checks++; if (con !== 1'b1) begin n_fail++; $display("FAIL reset_drain: consume %b, required 1", con); end
        if (con) begin
            exp = pop_exp();
            n_checks++; if (md !== exp) begin n_fail++; $display("FAIL reset_pop: got %h, required %h", md, exp); end
        end
    endtask

    task automatic test_streaming();
        bit acc, con; logic [31:0] md, exp; logic mv, sr; logic [1:0] occ;
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; s_data = 32'(i);
            tick(acc, con, md, mv, sr, occ);
            n_checks++; if (sr !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready[%0d]: got %b, required 1", i, sr); end
            if (i > 1) begin
                n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL stream_occupancy[%0d]: got %0d, required 1", i, occ); end
                n_checks++; if (con !== 1'b1) begin n_fail++; $display("FAIL stream_bubble[%0d]: consume %b, required 1", i, con); end
            end
            if (con) begin
                exp = pop_exp();
                n_checks++; if (md !== exp) begin n_fail++; $display("FAIL stream_data[%0d]: got %h, required %h", i, md, exp); end
            end
            if (acc) q.push_back(32'(i));
        end
        s_valid = 1'b0;
        tick(acc, con, md, mv, sr, occ);
        n_checks++; if (con !== 1'b1 || md !== 32'h10) begin n_fail++; $display("FAIL stream_last: consume %b data %h, required 1 00000010", con, md); end
        if (con) void'(pop_exp());
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL stream_leftover: %0d beats pending, required 0", q.size()); end
    endtask

    task automatic test_backpressure();
        bit acc, con; logic [31:0] md, exp; logic mv, sr; logic [1:0] occ;
        logic [31:0] vals[3];
        int idx;
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        idx = 0;
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_valid = 1'b1; s_data = vals[idx];
            tick(acc, con, md, mv, sr, occ);
            if (c >= 2) begin
                n_checks++; if (sr !== 1'b0 || occ !== 2'd2) begin n_fail++; $display("FAIL bp_full[%0d]: s_ready %b occ %0d, required 0 2", c, sr, occ); end
                n_checks++; if (md !== 32'hA) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h, required 0000000a", c, md); end
            end
            if (acc) begin q.push_back(vals[idx]); idx++; end
        end
        m_ready = 1'b1;
        tick(acc, con, md, mv, sr, occ);
        n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_skid_ready: accept %b on release cycle, required 0", acc); end
        if (con) begin
            exp = pop_exp();
            n_checks++; if (md !== exp) begin n_fail++; $display("FAIL bp_order: got %h, required %h", md, exp); end
        end
        if (acc) begin q.push_back(vals[idx]); idx++; end
        for (int c = 0; c < 4 && q.size() != 0; c++) begin
            s_valid = (idx < 3);
            if (idx < 3) s_data = vals[idx];
            tick(acc, con, md, mv, sr, occ);
            if (con) begin
                exp = pop_exp();
                n_checks++; if (md !== exp) begin n_fail++; $display("FAIL bp_order: got %h, required %h", md, exp); end
            end
            if (acc) begin q.push_back(vals[idx]); idx++; end
        end
        s_valid = 1'b0;
        n_checks++; if (idx != 3 || q.size() != 0) begin n_fail++; $display("FAIL bp_complete: sent %0d pending %0d, required 3 0", idx, q.size()); end
    endtask

    task automatic test_flush();
        bit acc, con; logic [31:0] md; logic mv, sr; logic [1:0] occ;
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 32'h11 * (i + 1);
            tick(acc, con, md, mv, sr, occ);
        end
        flush = 1'b1; s_valid = 1'b1; s_data = 32'h55;
        tick(acc, con, md, mv, sr, occ);
        n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_prefill: occ %0d, required 2", occ); end
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        q.delete();
        #1;
        n_checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_empty: m_valid %b occ %0d s_ready %b, required 0 0 1", m_valid, occupancy, s_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick(acc, con, md, mv, sr, occ);
            n_checks++; if (mv !== 1'b0) begin n_fail++; $display("FAIL flush_no_emit[%0d]: m_valid %b data %h, required 0", c, mv, md); end
        end
    endtask

    task automatic test_random();
        bit acc, con; logic [31:0] md, exp, prev_md, din; logic mv, sr, sr0; logic [1:0] occ;
        int sent, cycles, qs;
        bit prev_stall;
        sent = 0; cycles = 0; prev_stall = 1'b0; prev_md = '0;
        while (sent < 10000 && cycles < 40000) begin
            din = $urandom;
            s_valid = ($urandom_range(0, 9) < 7); s_data = din;
            m_ready = ($urandom_range(0, 9) < 6); flush = 1'b0;
            #1; sr0 = s_ready; m_ready = ~m_ready;
            #1;
            n_checks++; if (s_ready !== sr0) begin n_fail++; $display("FAIL rnd_comb_path: s_ready %b after m_ready toggle, required %b", s_ready, sr0); end
            m_ready = ~m_ready;
            tick(acc, con, md, mv, sr, occ);
            qs = q.size();
            n_checks++; if (occ !== 2'(qs) || mv !== (qs != 0) || sr !== (qs < 2)) begin
                n_fail++; $display("FAIL rnd_state[%0d]: occ %0d m_valid %b s_ready %b, required occ %0d", cycles, occ, mv, sr, qs);
            end
            if (prev_stall) begin
                n_checks++; if (md !== prev_md) begin n_fail++; $display("FAIL rnd_stall_stable[%0d]: got %h, required %h", cycles, md, prev_md); end
            end
            if (con) begin
                exp = pop_exp();
                n_checks++; if (md !== exp) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h, required %h", cycles, md, exp); end
            end
            if (acc) begin q.push_back(din); sent++; end
            prev_stall = mv && !m_ready;
            prev_md = md;
            cycles++;
        end
        n_checks++; if (sent != 10000) begin n_fail++; $display("FAIL rnd_budget: sent %0d beats, required 10000", sent); end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 4 && q.size() != 0; c++) begin
            tick(acc, con, md, mv, sr, occ);
            if (con) begin
                exp = pop_exp();
                n_checks++; if (md !== exp) begin n_fail++; $display("FAIL rnd_drain: got %h, required %h", md, exp); end
            end
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: %0d beats pending, required 0", q.size()); end
    endtask

    task automatic test_async_reset();
        bit acc, con; logic [31:0] md, exp; logic mv, sr; logic [1:0] occ;
        int pops;
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 32'hA1 + 32'(i);
            tick(acc, con, md, mv, sr, occ);
        end
        s_valid = 1'b0;
        n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL arst_prefill: occ %0d, required 2", occupancy); end
        #3; rst = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || occupancy !== 2'd0 || m_data !== 32'h0) begin
            n_fail++; $display("FAIL arst_immediate: m_valid %b s_ready %b occ %0d data %h, required 0 1 0 00000000", m_valid, s_ready, occupancy, m_data);
        end
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        tick(acc, con, md, mv, sr, occ);
        n_checks++; if (mv !== 1'b0) begin n_fail++; $display("FAIL arst_no_residue: m_valid %b data %h, required 0", mv, md); end
        s_valid = 1'b1; s_data = 32'h77; m_ready = 1'b1;
        tick(acc, con, md, mv, sr, occ);
        if (acc) q.push_back(32'h77);
        s_valid = 1'b0;
        pops = 0;
        for (int c = 0; c < 3; c++) begin
            tick(acc, con, md, mv, sr, occ);
            if (con) begin
                exp = pop_exp(); pops++;
                n_checks++; if (md !== exp) begin n_fail++; $display("FAIL arst_new_beat: got %h, required %h", md, exp); end
            end
        end
        n_checks++; if (pops != 1 || q.size() != 0) begin n_fail++; $display("FAIL arst_count: %0d beats emitted, required 1", pops); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
